// File: rtl/dma_engine.sv
// dma_engine: bus-master block copy/fill engine programmed through an 8-register config port.
// Requests the shared memory bus, moves bytes while granted, then releases it and reports done.
module dma_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  cfg_address,
    input  logic [7:0]  cfg_data_in,
    input  logic        cfg_write,
    output logic [7:0]  cfg_data_out,
    output logic        bus_request,
    input  logic        bus_grant,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  bus_data_in,
    output logic        bus_write_enable,
    output logic        done_irq
);
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_CAP  = 3'd3,
        S_WR      = 3'd4,
        S_WR_HOLD = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] len_q, len_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [DW-1:0] data_q, data_d;
    logic          fill_mode_q, fill_mode_d;
    logic          src_fixed_q, src_fixed_d;
    logic          irq_en_q, irq_en_d;
    logic          done_q, done_d;
    logic          aborted_q, aborted_d;
    logic          abort_pend_q, abort_pend_d;

    logic busy;
    logic ctrl_wr;
    logic abort_now;
    logic abort_any;

    assign busy      = (state_q == S_REQ) || (state_q == S_RD_ADDR) || (state_q == S_RD_CAP)
                    || (state_q == S_WR)  || (state_q == S_WR_HOLD);
    assign ctrl_wr   = cfg_write && (cfg_address == 3'd6);
    assign abort_now = ctrl_wr && cfg_data_in[7] && busy;
    assign abort_any = abort_now || abort_pend_q;

    // Next-state: transfer sequencing first, then idle-time config writes may override.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        fill_d       = fill_q;
        data_d       = data_q;
        fill_mode_d  = fill_mode_q;
        src_fixed_d  = src_fixed_q;
        irq_en_d     = irq_en_q;
        done_d       = done_q;
        aborted_d    = aborted_q;
        abort_pend_d = abort_pend_q;

        if (abort_now) begin
            abort_pend_d = 1'b1;
        end

        case (state_q)
            S_REQ: begin
                if (abort_any) begin
                    state_d      = S_DONE;
                    done_d       = 1'b1;
                    aborted_d    = 1'b1;
                    abort_pend_d = 1'b0;
                end else if (bus_grant) begin
                    state_d = fill_mode_q ? S_WR : S_RD_ADDR;
                end
            end
            S_RD_ADDR: state_d = bus_grant ? S_RD_CAP : S_REQ;
            S_RD_CAP: begin
                if (bus_grant) begin
                    data_d  = bus_data_in;
                    state_d = S_WR;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WR: state_d = bus_grant ? S_WR_HOLD : S_REQ;
            S_WR_HOLD: begin
                // Pointers advance only here, so a lost grant replays the current byte.
                if (!bus_grant) begin
                    state_d = S_REQ;
                end else begin
                    dst_d = dst_q + AW'(1);
                    if (!src_fixed_q && !fill_mode_q) begin
                        src_d = src_q + AW'(1);
                    end
                    len_d = len_q - LW'(1);
                    if ((len_q == LW'(1)) || abort_any) begin
                        state_d      = S_DONE;
                        done_d       = 1'b1;
                        aborted_d    = abort_any;
                        abort_pend_d = 1'b0;
                    end else begin
                        state_d = fill_mode_q ? S_WR : S_RD_ADDR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (cfg_write && !busy) begin
            case (cfg_address)
                3'd0: src_d[7:0]  = cfg_data_in;
                3'd1: src_d[15:8] = cfg_data_in;
                3'd2: dst_d[7:0]  = cfg_data_in;
                3'd3: dst_d[15:8] = cfg_data_in;
                3'd4: len_d[7:0]  = cfg_data_in;
                3'd5: len_d[15:8] = cfg_data_in;
                3'd6: begin
                    irq_en_d = cfg_data_in[3];
                    if (cfg_data_in[6]) begin
                        done_d = 1'b0;
                    end
                    if (cfg_data_in[0]) begin
                        fill_mode_d  = cfg_data_in[1];
                        src_fixed_d  = cfg_data_in[2];
                        abort_pend_d = 1'b0;
                        if (len_q != '0) begin
                            done_d    = 1'b0;
                            aborted_d = 1'b0;
                            state_d   = S_REQ;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                default: fill_d = cfg_data_in;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            fill_q       <= '0;
            data_q       <= '0;
            fill_mode_q  <= 1'b0;
            src_fixed_q  <= 1'b0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            fill_q       <= fill_d;
            data_q       <= data_d;
            fill_mode_q  <= fill_mode_d;
            src_fixed_q  <= src_fixed_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    // Bus drive decoded from state; the write strobe is also gated by the live grant.
    always_comb begin
        bus_request      = busy;
        bus_address      = '0;
        bus_data_out     = '0;
        bus_write_enable = 1'b0;
        case (state_q)
            S_RD_ADDR, S_RD_CAP: bus_address = src_q;
            S_WR, S_WR_HOLD: begin
                bus_address      = dst_q;
                bus_data_out     = fill_mode_q ? fill_q : data_q;
                bus_write_enable = (state_q == S_WR) && bus_grant;
            end
            default: ;
        endcase
    end

    assign done_irq = done_q && irq_en_q;

    always_comb begin
        cfg_data_out = '0;
        case (cfg_address)
            3'd0:    cfg_data_out = src_q[7:0];
            3'd1:    cfg_data_out = src_q[15:8];
            3'd2:    cfg_data_out = dst_q[7:0];
            3'd3:    cfg_data_out = dst_q[15:8];
            3'd4:    cfg_data_out = len_q[7:0];
            3'd5:    cfg_data_out = len_q[15:8];
            3'd6:    cfg_data_out = {4'b0000, irq_en_q, aborted_q, done_q, busy};
            default: cfg_data_out = fill_q;
        endcase
    end

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine: copy, fill, grant loss, abort, zero-length start and reset.
module tb_dma_engine;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  cfg_address = '0;
    logic [7:0]  cfg_data_in = '0;
    logic        cfg_write = 1'b0;
    logic [7:0]  cfg_data_out;
    logic        bus_request;
    logic        bus_grant = 1'b1;
    logic [15:0] bus_address;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_in;
    logic        bus_write_enable;
    logic        done_irq;

    int vectors = 0;
    int miscompares = 0;

    dma_engine dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_address      (cfg_address),
        .cfg_data_in      (cfg_data_in),
        .cfg_write        (cfg_write),
        .cfg_data_out     (cfg_data_out),
        .bus_request      (bus_request),
        .bus_grant        (bus_grant),
        .bus_address      (bus_address),
        .bus_data_out     (bus_data_out),
        .bus_data_in      (bus_data_in),
        .bus_write_enable (bus_write_enable),
        .done_irq         (done_irq)
    );

    always #10 clk = ~clk;

    // Memory model: synchronous read (data valid the cycle after the address) and a write log.
    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        int unsigned c;
    } wr_t;

    logic [7:0]  mem [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;
    int unsigned cyc = 0;
    wr_t         wlog [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus_data_in <= mem[bus_address];
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (bus_write_enable) begin
            mem[bus_address] <= bus_data_out;
            wlog.push_back('{bus_address, bus_data_out, cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [2:0] a, input logic [7:0] d);
        cfg_address = a;
        cfg_data_in = d;
        cfg_write   = 1'b1;
        @(posedge clk);
        #1;
        cfg_write   = 1'b0;
    endtask

    task automatic cfg_rd(input logic [2:0] a, output logic [7:0] d);
        cfg_address = a;
        #1;
        d = cfg_data_out;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic setup(input logic [15:0] s, input logic [15:0] t, input logic [15:0] n,
                         input logic [7:0] f);
        logic [15:0] sv;
        logic [15:0] tv;
        logic [15:0] nv;
        sv = s;
        tv = t;
        nv = n;
        cfg_wr(3'd0, sv[7:0]);
        cfg_wr(3'd1, sv[15:8]);
        cfg_wr(3'd2, tv[7:0]);
        cfg_wr(3'd3, tv[15:8]);
        cfg_wr(3'd4, nv[7:0]);
        cfg_wr(3'd5, nv[15:8]);
        cfg_wr(3'd7, f);
    endtask

    task automatic test_reset();
        logic [7:0] r;
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if (bus_request !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", bus_request); end
        vectors++;
        if (bus_write_enable !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", bus_write_enable); end
        vectors++;
        if (bus_address !== 16'h0000) begin miscompares++; $display("FAIL reset_addr: got %h want 0000", bus_address); end
        vectors++;
        if (bus_data_out !== 8'h00) begin miscompares++; $display("FAIL reset_dout: got %h want 00", bus_data_out); end
        vectors++;
        if (done_irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", done_irq); end
        for (int i = 0; i < 8; i++) begin
            cfg_rd(3'(i), r);
            vectors++;
            if (r !== 8'h00) begin miscompares++; $display("FAIL reset_reg%0d: got %h want 00", i, r); end
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_copy();
        logic [7:0] r;
        logic [7:0] exp_d [3];
        exp_d[0] = 8'hA1;
        exp_d[1] = 8'hB2;
        exp_d[2] = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            preload(16'h0010 + 16'(i), exp_d[i]);
            preload(16'h0100 + 16'(i), 8'h00);
        end
        bus_grant = 1'b1;
        setup(16'h0010, 16'h0100, 16'd3, 8'h00);
        wlog.delete();
        cfg_wr(3'd6, 8'h01);
        vectors++;
        if (bus_request !== 1'b1) begin miscompares++; $display("FAIL copy_req_rise: got %b want 1", bus_request); end
        for (int i = 0; i < 12; i++) tick();
        cfg_rd(3'd6, r);
        vectors++;
        if (r !== 8'h01) begin miscompares++; $display("FAIL copy_busy_c13: got %h want 01", r); end
        tick();
        cfg_rd(3'd6, r);
        vectors++;
        if (r !== 8'h02) begin miscompares++; $display("FAIL copy_done_c14: got %h want 02", r); end
        vectors++;
        if (bus_request !== 1'b0) begin miscompares++; $display("FAIL copy_release: got %b want 0", bus_request); end
        tick();
        vectors++;
        if (wlog.size() !== 3) begin miscompares++; $display("FAIL copy_nwrites: got %0d want 3", wlog.size()); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (mem[16'h0100 + 16'(i)] !== exp_d[i]) begin
                miscompares++;
                $display("FAIL copy_mem%0d: got %h want %h", i, mem[16'h0100 + 16'(i)], exp_d[i]);
            end
        end
        if (wlog.size() == 3) begin
            vectors++;
            if (wlog[1].c - wlog[0].c !== 4) begin miscompares++; $display("FAIL copy_spacing: got %0d want 4", wlog[1].c - wlog[0].c); end
        end
        cfg_rd(3'd4, r);
        vectors++;
        if (r !== 8'h00) begin miscompares++; $display("FAIL copy_len_lo: got %h want 00", r); end
        cfg_rd(3'd5, r);
        vectors++;
        if (r !== 8'h00) begin miscompares++; $display("FAIL copy_len_hi: got %h want 00", r); end
        cfg_rd(3'd0, r);
        vectors++;
        if (r !== 8'h13) begin miscompares++; $display("FAIL copy_src_lo: got %h want 13", r); end
        cfg_rd(3'd2, r);
        vectors++;
        if (r !== 8'h03) begin miscompares++; $display("FAIL copy_dst_lo: got %h want 03", r); end
    endtask

    task automatic test_fill();
        logic [7:0]  r;
        logic [15:0] exp_a [4];
        exp_a[0] = 16'h01FE;
        exp_a[1] = 16'h01FF;
        exp_a[2] = 16'h0200;
        exp_a[3] = 16'h0201;
        setup(16'h4321, 16'h01FE, 16'd4, 8'h5A);
        wlog.delete();
        cfg_wr(3'd6, 8'h03);
        for (int i = 0; i < 9; i++) tick();
        cfg_rd(3'd6, r);
        vectors++;
        if (r !== 8'h02) begin miscompares++; $display("FAIL fill_done: got %h want 02", r); end
        tick();
        vectors++;
        if (wlog.size() !== 4) begin miscompares++; $display("FAIL fill_nwrites: got %0d want 4", wlog.size()); end
        if (wlog.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (wlog[i].a !== exp_a[i] || wlog[i].d !== 8'h5A) begin
                    miscompares++;
                    $display("FAIL fill_wr%0d: got %h/%h want %h/5a", i, wlog[i].a, wlog[i].d, exp_a[i]);
                end
            end
            vectors++;
            if (wlog[3].c - wlog[2].c !== 2) begin miscompares++; $display("FAIL fill_spacing: got %0d want 2", wlog[3].c - wlog[2].c); end
        end
        cfg_rd(3'd0, r);
        vectors++;
        if (r !== 8'h21) begin miscompares++; $display("FAIL fill_src_lo: got %h want 21", r); end
        cfg_rd(3'd1, r);
        vectors++;
        if (r !== 8'h43) begin miscompares++; $display("FAIL fill_src_hi: got %h want 43", r); end

        cfg_wr(3'd2, 8'hFF);
        cfg_wr(3'd3, 8'hFF);
        cfg_wr(3'd4, 8'h02);
        cfg_wr(3'd5, 8'h00);
        wlog.delete();
        cfg_wr(3'd6, 8'h03);
        for (int i = 0; i < 6; i++) tick();
        vectors++;
        if (wlog.size() !== 2) begin miscompares++; $display("FAIL wrap_nwrites: got %0d want 2", wlog.size()); end
        if (wlog.size() == 2) begin
            vectors++;
            if (wlog[0].a !== 16'hFFFF || wlog[1].a !== 16'h0000) begin
                miscompares++;
                $display("FAIL wrap_addr: got %h,%h want ffff,0000", wlog[0].a, wlog[1].a);
            end
        end
        cfg_rd(3'd2, r);
        vectors++;
        if (r !== 8'h01) begin miscompares++; $display("FAIL wrap_dst_lo: got %h want 01", r); end
    endtask

    task automatic test_grant_drop();
        logic [7:0] r;
        logic       seen;
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h11;
        exp_d[1] = 8'h22;
        exp_d[2] = 8'h33;
        exp_d[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            preload(16'h0020 + 16'(i), exp_d[i]);
            preload(16'h0300 + 16'(i), 8'h00);
        end
        setup(16'h0020, 16'h0300, 16'd4, 8'h00);
        wlog.delete();
        cfg_wr(3'd6, 8'h01);
        for (int i = 0; i < 7; i++) tick();
        vectors++;
        if (bus_write_enable !== 1'b1 || bus_address !== 16'h0301) begin
            miscompares++;
            $display("FAIL gd_in_wr2: got we=%b addr=%h want we=1 addr=0301", bus_write_enable, bus_address);
        end
        bus_grant = 1'b0;
        #1;
        vectors++;
        if (bus_write_enable !== 1'b0) begin miscompares++; $display("FAIL gd_we_gated: got %b want 0", bus_write_enable); end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (bus_request !== 1'b1 || bus_write_enable !== 1'b0) begin
                miscompares++;
                $display("FAIL gd_hold%0d: got req=%b we=%b want req=1 we=0", i, bus_request, bus_write_enable);
            end
        end
        bus_grant = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            cfg_rd(3'd6, r);
            if (r[1]) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b1) begin miscompares++; $display("FAIL gd_timeout: got done=%b want 1", seen); end
        tick();
        vectors++;
        if (wlog.size() !== 4) begin miscompares++; $display("FAIL gd_nwrites: got %0d want 4", wlog.size()); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (mem[16'h0300 + 16'(i)] !== exp_d[i]) begin
                miscompares++;
                $display("FAIL gd_mem%0d: got %h want %h", i, mem[16'h0300 + 16'(i)], exp_d[i]);
            end
            if (i < wlog.size()) begin
                vectors++;
                if (wlog[i].a !== 16'h0300 + 16'(i)) begin
                    miscompares++;
                    $display("FAIL gd_order%0d: got %h want %h", i, wlog[i].a, 16'h0300 + 16'(i));
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] r;
        for (int i = 0; i < 10; i++) preload(16'h0040 + 16'(i), 8'h60 + 8'(i));
        setup(16'h0040, 16'h0500, 16'd10, 8'h00);
        wlog.delete();
        cfg_wr(3'd6, 8'h01);
        for (int i = 0; i < 6; i++) tick();
        cfg_wr(3'd6, 8'h80);
        tick();
        cfg_rd(3'd6, r);
        vectors++;
        if (r !== 8'h01) begin miscompares++; $display("FAIL abort_still_busy: got %h want 01", r); end
        tick();
        cfg_rd(3'd6, r);
        vectors++;
        if (r !== 8'h06) begin miscompares++; $display("FAIL abort_status: got %h want 06", r); end
        vectors++;
        if (bus_request !== 1'b0) begin miscompares++; $display("FAIL abort_release: got %b want 0", bus_request); end
        cfg_rd(3'd4, r);
        vectors++;
        if (r !== 8'h08) begin miscompares++; $display("FAIL abort_len: got %h want 08", r); end
        tick();
        vectors++;
        if (wlog.size() !== 2) begin miscompares++; $display("FAIL abort_nwrites: got %0d want 2", wlog.size()); end
        vectors++;
        if (mem[16'h0501] !== 8'h61) begin miscompares++; $display("FAIL abort_byte2: got %h want 61", mem[16'h0501]); end
    endtask

    task automatic test_len0_irq();
        logic [7:0] r;
        cfg_wr(3'd4, 8'h00);
        cfg_wr(3'd5, 8'h00);
        cfg_wr(3'd6, 8'h09);
        vectors++;
        if (done_irq !== 1'b1) begin miscompares++; $display("FAIL len0_irq: got %b want 1", done_irq); end
        cfg_rd(3'd6, r);
        vectors++;
        if ((r & 8'h0B) !== 8'h0A) begin miscompares++; $display("FAIL len0_status: got %h want done|irq_en", r); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus_request !== 1'b0) begin miscompares++; $display("FAIL len0_noreq%0d: got %b want 0", i, bus_request); end
            tick();
        end
        cfg_wr(3'd6, 8'h40);
        vectors++;
        if (done_irq !== 1'b0) begin miscompares++; $display("FAIL len0_clear_irq: got %b want 0", done_irq); end
        cfg_rd(3'd6, r);
        vectors++;
        if (r[1] !== 1'b0) begin miscompares++; $display("FAIL len0_clear_done: got %b want 0", r[1]); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        setup(16'h0010, 16'h0600, 16'd3, 8'h77);
        cfg_wr(3'd6, 8'h09);
        for (int i = 0; i < 5; i++) tick();
        vectors++;
        if (bus_request !== 1'b1 || bus_address !== 16'h0011) begin
            miscompares++;
            $display("FAIL rm_active: got req=%b addr=%h want req=1 addr=0011", bus_request, bus_address);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (bus_request !== 1'b0 || bus_write_enable !== 1'b0 || bus_address !== 16'h0000) begin
            miscompares++;
            $display("FAIL rm_bus: got req=%b we=%b addr=%h want 0/0/0000", bus_request, bus_write_enable, bus_address);
        end
        for (int i = 0; i < 8; i++) begin
            cfg_rd(3'(i), r);
            vectors++;
            if (r !== 8'h00) begin miscompares++; $display("FAIL rm_reg%0d: got %h want 00", i, r); end
        end
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_copy();
        test_fill();
        test_grant_drop();
        test_abort();
        test_len0_irq();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dma_engine.md
# dma_engine

Bus-master block copy/fill engine that drives the same address/data/write_enable bus the CPU uses into `memory_bus`. The CPU programs source, destination, length and mode through an 8-register config port, then sets start. The engine requests the bus, and once granted it moves bytes RAM/ROM/peripherals → RAM/peripherals. When the transfer ends it releases the bus and raises done and an optional interrupt.

## Interface
Parameters:
- none (16-bit addresses, 8-bit data, 16-bit length fixed)

Ports:
- clk  in  1  system clock, the CPU/bus clock. Single clock domain.
- reset  in  1  synchronous, active-low reset
- cfg_address  in  3  config register select
- cfg_data_in  in  8  config write data
- cfg_write  in  1  config write strobe, sampled at posedge clk
- cfg_data_out  out  8  config read data, combinational from cfg_address
- bus_request  out  1  engine wants the memory bus
- bus_grant  in  1  CPU has stopped and released the bus
- bus_address  out  16  memory_bus address
- bus_data_out  out  8  write data to memory_bus
- bus_data_in  in  8  read data from memory_bus
- bus_write_enable  out  1  memory_bus write strobe
- done_irq  out  1  done AND irq_enable

## Operation
Register map:
- 0/1: src lo/hi
- 2/3: dst lo/hi
- 4/5: len lo/hi. Reads return the remaining count.
- 6 ctrl
  - Write bits: 0 start, 1 fill_mode, 2 src_fixed, 3 irq_enable, 6 clear_done, 7 abort.
  - Read bits: 0 busy, 1 done, 2 aborted, 3 irq_enable.
- 7: fill value

Config rules:
- Writes to registers 0–5 and 7 while busy are ignored.
- Writes to ctrl while busy act only on abort.
- Start with len≠0:
  - Latches the mode bits and sets busy.
  - Clears done and aborted.
  - Goes to REQ.
- Start with len=0: sets done, no bus activity.

States:
- IDLE: bus_request=0, bus outputs 0.
- REQ: bus_request=1. Go to RD_ADDR (copy) or WR (fill) when bus_grant=1.
- RD_ADDR: bus_address=src, we=0. Next state is RD_CAP.
- RD_CAP: bus_address=src held. Latch bus_data_in into the data register. Next state is WR.
- WR: bus_address=dst, bus_data_out=data (or the fill value), bus_write_enable=1. Next state is WR_HOLD.
- WR_HOLD: address and data held, we=0.
  - dst+=1.
  - src+=1 unless src_fixed or fill_mode.
  - len-=1.
  - If len becomes 0, go to DONE. Otherwise go to RD_ADDR (copy) or WR (fill).
- DONE: bus_request=0, busy=0, done=1. Next state is IDLE.

Arithmetic: src and dst are 16-bit and wrap 0xFFFF→0x0000. len is 16-bit; len=0xFFFF moves 65535 bytes.

Boundary cases:
- bus_grant dropping mid-transfer:
  - In any active state, the engine forces bus_write_enable=0 and returns to REQ.
  - Resume restarts the current byte: src, dst and len are unchanged, because the advance happens only in WR_HOLD.
- Abort:
  - Sampled any time busy.
  - In REQ, abort takes effect immediately.
  - Otherwise it takes effect at the next WR_HOLD. That byte completes, then the engine goes to DONE with aborted=1 and len holding the remaining count.
- Simultaneous start and abort in one write: start wins if idle; abort wins if busy.
- clear_done and start in the same write: start wins (done=0).

Reset values (reset low at posedge):
- All registers 0. State IDLE.
- All outputs 0: bus_request=0, bus_write_enable=0, bus_address=0, bus_data_out=0, done_irq=0.
- Reset mid-transfer releases the bus in the same cycle the reset is sampled.

## Timing
- Start-write edge → bus_request=1 on the next cycle.
- Grant sampled high in REQ → first bus cycle (RD_ADDR or WR) on the next cycle.
- Copy costs 4 clk per byte; fill costs 2 clk per byte.
- Total for N bytes, grant already high: 1 (REQ) + 4N (copy) or 2N (fill) cycles, then DONE.
- Read data from memory_bus is valid one cycle after the address is presented and is captured in RD_CAP.
- bus_write_enable is high for exactly one cycle per byte. Address and data are stable in that cycle and the following one.
- done and done_irq rise the cycle after the final WR_HOLD. bus_request falls in that same cycle.
- cfg_data_out is combinational with no latency.

## Test plan
- Copy: src=0x0010, dst=0x0100, len=3, RAM[0x10..0x12]=A1,B2,C3, grant tied high.
  - RAM[0x100..0x102]=A1,B2,C3.
  - Exactly 3 write pulses.
  - done at cycle 14 after start.
  - len reads 0.
- Fill: dst=0x01FE, len=4, fill=0x5A.
  - Writes land at 0x01FE, 0x01FF, 0x0200, 0x0201, 2 clk apart.
  - src is unchanged.
  - A second case with dst=0xFFFF, len=2 writes 0xFFFF then 0x0000.
- Grant drop: drop bus_grant during the WR of byte 2 of a 4-byte copy, hold low 5 cycles.
  - Write is suppressed and bus_request stays high.
  - The byte is redone after regrant.
  - Final memory is correct with no duplicate or skipped bytes.
- Abort: write ctrl=0x80 during the RD_CAP of byte 2 of len=10.
  - Byte 2 completes, then done=1 and aborted=1.
  - len reads 8.
  - The bus is released.
- len=0 start with irq_enable=1:
  - bus_request never rises.
  - done_irq=1 the next cycle.
  - ctrl write 0x40 clears it.
- Reset low mid-copy:
  - The next cycle has bus_request=0, we=0, address=0.
  - All registers read 0.
